// File: rtl/sal_bk_ctrl.sv
// Single-bank DDR2 state tracker: FSM plus timing counters that qualify ACT/RD/WR/PRE/REF.
// The *_ok outputs depend only on registered state, so a controller can use them to arbitrate.
module sal_bk_ctrl #(
  parameter int ROW_WIDTH = 14,
  parameter int TW        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TW-1:0]        t_rcd,
  input  logic [TW-1:0]        t_rp,
  input  logic [TW-1:0]        t_ras,
  input  logic [TW-1:0]        t_rfc,
  input  logic [TW-1:0]        t_rtp,
  input  logic [TW-1:0]        t_wtp,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_type,
  input  logic [ROW_WIDTH-1:0] cmd_row,
  output logic                 act_ok,
  output logic                 rdwr_ok,
  output logic                 pre_ok,
  output logic                 ref_ok,
  output logic                 bank_open,
  output logic [ROW_WIDTH-1:0] open_row,
  output logic                 cmd_err
);

  typedef enum logic [2:0] {
    IDLE, ACTIVATING, ACTIVE, PRECHARGING, REFRESHING
  } state_t;

  localparam logic [2:0] C_ACT = 3'd0;
  localparam logic [2:0] C_RD  = 3'd1;
  localparam logic [2:0] C_WR  = 3'd2;
  localparam logic [2:0] C_PRE = 3'd3;
  localparam logic [2:0] C_REF = 3'd4;

  state_t          state, state_nxt;
  logic [TW-1:0]   rcd_cnt, rp_cnt, ras_cnt, rfc_cnt, rtp_cnt, wtp_cnt;
  logic            acc_act, acc_rd, acc_wr, acc_pre, acc_ref, accepted;

  // A counter value of c means the constraint is met c cycles from now, so a
  // constraint of T issued this cycle loads max(T,1)-1.
  function automatic logic [TW-1:0] ld_val(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  // Reload never shortens a constraint that is still running.
  function automatic logic [TW-1:0] cnt_nxt(input logic [TW-1:0] c,
                                            input logic [TW-1:0] t,
                                            input logic          load);
    logic [TW-1:0] d, l;
    d = dec(c);
    l = ld_val(t);
    return (load && (l > d)) ? l : d;
  endfunction

  assign act_ok    = (state == IDLE) && (rp_cnt == '0) && (rfc_cnt == '0);
  assign ref_ok    = act_ok;
  assign rdwr_ok   = (state == ACTIVE);
  assign pre_ok    = (state == ACTIVE) && (ras_cnt == '0) &&
                     (rtp_cnt == '0) && (wtp_cnt == '0);
  assign bank_open = (state == ACTIVE) || (state == ACTIVATING);

  assign acc_act  = cmd_valid && (cmd_type == C_ACT) && act_ok;
  assign acc_rd   = cmd_valid && (cmd_type == C_RD)  && rdwr_ok;
  assign acc_wr   = cmd_valid && (cmd_type == C_WR)  && rdwr_ok;
  assign acc_pre  = cmd_valid && (cmd_type == C_PRE) && pre_ok;
  assign acc_ref  = cmd_valid && (cmd_type == C_REF) && ref_ok;
  assign accepted = acc_act || acc_rd || acc_wr || acc_pre || acc_ref;

  // Transient states leave exactly on the cycle their counter hits zero; a
  // constraint of 0 or 1 skips the transient state entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_act)      state_nxt = (ld_val(t_rcd) == '0) ? ACTIVE : ACTIVATING;
        else if (acc_ref) state_nxt = (ld_val(t_rfc) == '0) ? IDLE : REFRESHING;
      end
      ACTIVATING:  if (rcd_cnt <= 1) state_nxt = ACTIVE;
      ACTIVE:      if (acc_pre) state_nxt = (ld_val(t_rp) == '0) ? IDLE : PRECHARGING;
      PRECHARGING: if (rp_cnt <= 1) state_nxt = IDLE;
      REFRESHING:  if (rfc_cnt <= 1) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rcd_cnt  <= '0;
      rp_cnt   <= '0;
      ras_cnt  <= '0;
      rfc_cnt  <= '0;
      rtp_cnt  <= '0;
      wtp_cnt  <= '0;
      open_row <= '0;
      cmd_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      rcd_cnt <= cnt_nxt(rcd_cnt, t_rcd, acc_act);
      ras_cnt <= cnt_nxt(ras_cnt, t_ras, acc_act);
      rtp_cnt <= cnt_nxt(rtp_cnt, t_rtp, acc_rd);
      wtp_cnt <= cnt_nxt(wtp_cnt, t_wtp, acc_wr);
      rp_cnt  <= cnt_nxt(rp_cnt,  t_rp,  acc_pre);
      rfc_cnt <= cnt_nxt(rfc_cnt, t_rfc, acc_ref);
      if (acc_act) open_row <= cmd_row;
      cmd_err <= cmd_valid && !accepted;
    end
  end

endmodule

// File: tb/tb_sal_bk_ctrl.sv
// Directed bench for sal_bk_ctrl: linear command script with hand-computed expectations.
module tb_sal_bk_ctrl;

  localparam int RW = 14;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [TW-1:0] t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp;
  logic          cmd_valid;
  logic [2:0]    cmd_type;
  logic [RW-1:0] cmd_row;
  logic          act_ok, rdwr_ok, pre_ok, ref_ok, bank_open, cmd_err;
  logic [RW-1:0] open_row;

  int n_chk  = 0;
  int n_fail = 0;

  sal_bk_ctrl #(.ROW_WIDTH(RW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rfc(t_rfc),
    .t_rtp(t_rtp), .t_wtp(t_wtp),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_row(cmd_row),
    .act_ok(act_ok), .rdwr_ok(rdwr_ok), .pre_ok(pre_ok), .ref_ok(ref_ok),
    .bank_open(bank_open), .open_row(open_row), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic cmd(input logic [2:0] t, input logic [RW-1:0] row = '0);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_row   = row;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_type  = 3'd0;
    cmd_row   = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    t_rcd = 8'd4; t_ras = 8'd10; t_rtp = 8'd3; t_wtp = 8'd2;
    t_rp  = 8'd5; t_rfc = 8'd200;
    idle();
    step(2);
    rst_n = 1'b1;

    // Reset values
    chk("rst_act_ok",   act_ok,    1);
    chk("rst_ref_ok",   ref_ok,    1);
    chk("rst_rdwr_ok",  rdwr_ok,   0);
    chk("rst_pre_ok",   pre_ok,    0);
    chk("rst_open",     bank_open, 0);
    chk("rst_row",      open_row,  0);
    chk("rst_err",      cmd_err,   0);

    // ACT row 0x155, tRCD=4 (cycle A)
    cmd(3'd0, 14'h155);
    step(); idle();                       // A+1
    chk("act_row",      open_row,  14'h155);
    chk("act_open",     bank_open, 1);
    chk("act_rdwr_a1",  rdwr_ok,   0);
    chk("act_actok_a1", act_ok,    0);
    step();                               // A+2
    chk("act_rdwr_a2",  rdwr_ok,   0);
    step();                               // A+3
    chk("act_rdwr_a3",  rdwr_ok,   0);
    step();                               // A+4
    chk("act_rdwr_a4",  rdwr_ok,   1);
    chk("act_pre_a4",   pre_ok,    0);

    // RD at A+8 with tRTP=3: tRAS done at A+10, PRE held until A+11
    step(4);                              // A+8
    cmd(3'd1);
    step(); idle();                       // A+9
    chk("rd_pre_a9",    pre_ok,    0);
    step();                               // A+10
    chk("rd_pre_a10",   pre_ok,    0);
    step();                               // A+11
    chk("rd_pre_a11",   pre_ok,    1);

    // WR at A+11 with tWTP=2 -> PRE legal again at A+13
    cmd(3'd2);
    step(); idle();                       // A+12
    chk("wr_pre_a12",   pre_ok,    0);
    step();                               // A+13
    chk("wr_pre_a13",   pre_ok,    1);

    // RD tRTP=6 then RD tRTP=1: shorter reload must not cut the pending wait
    t_rtp = 8'd6; cmd(3'd1);
    step();                               // A+14
    t_rtp = 8'd1; cmd(3'd1);
    step(); idle();                       // A+15
    step(3);                              // A+18
    chk("rtp_max_a18",  pre_ok,    0);
    step();                               // A+19
    chk("rtp_max_a19",  pre_ok,    1);

    // PRE with tRP=5 at cycle P
    cmd(3'd3);
    step(); idle();                       // P+1
    chk("pre_open",     bank_open, 0);
    chk("pre_actok_p1", act_ok,    0);
    chk("pre_row_hold", open_row,  14'h155);
    step();                               // P+2: illegal ACT
    cmd(3'd0, 14'h2aa);
    step(); idle();                       // P+3
    chk("ill_err",      cmd_err,   1);
    chk("ill_open",     bank_open, 0);
    chk("ill_row",      open_row,  14'h155);
    chk("ill_actok_p3", act_ok,    0);
    step();                               // P+4
    chk("ill_err_pulse", cmd_err,  0);
    chk("pre_actok_p4", act_ok,    0);
    step();                               // P+5
    chk("pre_actok_p5", act_ok,    1);

    // Zero timings: REF then ACT then PRE, each legal one cycle later
    t_rfc = 8'd0; t_rcd = 8'd0; t_ras = 8'd0; t_rp = 8'd0;
    cmd(3'd4);
    step();                               // P+6
    chk("z_actok",      act_ok,    1);
    cmd(3'd0, 14'h0a5);
    step();                               // P+7
    chk("z_rdwr",       rdwr_ok,   1);
    chk("z_pre_ok",     pre_ok,    1);
    chk("z_row",        open_row,  14'h0a5);
    chk("z_err",        cmd_err,   0);
    cmd(3'd3);
    step(); idle();                       // P+8
    chk("z_actok2",     act_ok,    1);
    chk("z_open",       bank_open, 0);

    // REF tRFC=200, t_rfc changed to 5 on the next cycle (cycle R)
    t_rfc = 8'd200; cmd(3'd4);
    step(); idle();                       // R+1
    t_rfc = 8'd5;
    chk("rfc_actok_r1", act_ok,    0);
    step(198);                            // R+199
    chk("rfc_actok_r199", act_ok,  0);
    chk("rfc_refok_r199", ref_ok,  0);
    step();                               // R+200
    chk("rfc_actok_r200", act_ok,  1);

    // Reset during ACTIVATING (cycle S)
    t_rcd = 8'd4; cmd(3'd0, 14'h3c3);
    step(); idle();                       // S+1
    chk("rs_open_s1",   bank_open, 1);
    rst_n = 1'b0;
    step();                               // S+2
    rst_n = 1'b1;
    chk("rs_open",      bank_open, 0);
    chk("rs_actok",     act_ok,    1);
    chk("rs_row",       open_row,  0);
    cmd(3'd0, 14'h012);
    step();                               // S+3
    chk("rs_act_open",  bank_open, 1);
    chk("rs_act_row",   open_row,  14'h012);
    cmd(3'd5);
    step(); idle();                       // S+4
    chk("rsv_err",      cmd_err,   1);
    chk("rsv_open",     bank_open, 1);
    chk("rsv_rdwr",     rdwr_ok,   0);
    step(2);                              // S+6
    chk("rs_rdwr_s6",   rdwr_ok,   1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sal_bk_ctrl.md
SAL_BK_CTRL -- requirements
Module: SAL_BK_CTRL

Interface
REQ-001 Parameter ROW_WIDTH, default 14, is the DDR2 row address width.
REQ-002 Parameter TW, default 8, is the width of every timing input, in clock cycles.
REQ-003 clk  input  1  is the single clock of the block.
REQ-004 rst_n  input  1  is a synchronous, active-low reset.
REQ-005 t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp  input  TW each  are the bank timing values from SAL_CFG.
REQ-006 cmd_valid  input  1  means a command is presented this cycle.
REQ-007 cmd_type  input  3  is the command code: 0 ACT, 1 RD, 2 WR, 3 PRE, 4 REF; codes 5-7 are reserved.
REQ-008 cmd_row  input  ROW_WIDTH  is the row address, used only with ACT.
REQ-009 act_ok, rdwr_ok, pre_ok, ref_ok  output  1 each  mean the matching command is legal this cycle.
REQ-010 bank_open  output  1  means a row is open: state ACTIVE, or ACTIVATING with tRCD still pending.
REQ-011 open_row  output  ROW_WIDTH  is the currently open row.
REQ-012 cmd_err  output  1  is a one-cycle pulse marking an illegal or reserved command.

Function
REQ-013 FSM states and transitions SHALL be exactly:
- IDLE: bank precharged.
- ACTIVATING: entered from IDLE on ACT; goes to ACTIVE once tRCD expires.
- ACTIVE: RD/WR keep it in ACTIVE.
- PRECHARGING: entered from ACTIVE on PRE; goes to IDLE once tRP expires.
- REFRESHING: entered from IDLE on REF; goes to IDLE once tRFC expires.
REQ-014 A command is accepted when cmd_valid=1 and the matching *_ok=1 in the same cycle; the state and counters update at the next clock edge.
REQ-015 Timing rule: a constraint of value T started by a command accepted at cycle N is satisfied from cycle N+max(T,1) onward.
REQ-016 Timing values are captured when the command is accepted; changes on t_* mid-countdown SHALL NOT affect a running count.
REQ-017 ACT SHALL load the tRCD and tRAS counters and capture cmd_row into open_row.
REQ-018 RD SHALL load the tRTP counter; WR SHALL load the tWTP counter.
- Each load takes the max of the remaining count and the new value, so it never shortens a pending constraint.
REQ-019 PRE SHALL load the tRP counter; REF SHALL load the tRFC counter.
REQ-020 act_ok = 1 only in IDLE with the tRP and tRFC constraints satisfied.
REQ-021 ref_ok SHALL use the same condition as act_ok.
REQ-022 rdwr_ok = 1 only in ACTIVE; ACTIVATING reaches ACTIVE exactly when tRCD is satisfied.
REQ-023 pre_ok = 1 only in ACTIVE with the tRAS, tRTP and tWTP constraints all satisfied.
REQ-024 The *_ok outputs SHALL be combinational from registered state and counters, with no dependence on cmd_* inputs.
REQ-025 An illegal command (cmd_valid=1 with the matching ok=0) or a reserved code SHALL be ignored, with no state or counter change.
- cmd_err is asserted in the following cycle for one cycle.
REQ-026 Counters decrement by one per cycle and saturate at 0, with no wrap-around.
REQ-027 Timing inputs are TW bits, so the maximum constraint is 2^TW-1 cycles.
REQ-028 A command accepted in the same cycle a counter reaches 0 is legal.
REQ-029 bank_open deasserts in the cycle after PRE is accepted.
REQ-030 open_row SHALL hold its value after PRE until the next ACT.

Reset
REQ-031 On a clk edge with rst_n=0, state SHALL go to IDLE and all counters to 0, aborting any countdown in progress.
REQ-032 On that reset edge, open_row and cmd_err SHALL go to 0.
REQ-033 Output values after reset: act_ok=1, ref_ok=1, rdwr_ok=0, pre_ok=0, bank_open=0.
REQ-034 Reset asserted mid-operation (e.g. during REFRESHING) SHALL be legal.
- ACT is accepted in the first cycle after rst_n returns to 1.

Verification
REQ-035 Scenario 1: t_rcd=4; ACT row 0x155 at cycle 10.
- Response: rdwr_ok=0 for cycles 11-13 and 1 at cycle 14; open_row=0x155 from cycle 11.
REQ-036 Scenario 2: t_ras=10, t_rtp=3; ACT at cycle 0, RD at cycle 8.
- Response: pre_ok first 1 at cycle 11, set by tRTP and not tRAS.
REQ-037 Scenario 3: t_rp=5; PRE accepted at cycle 20.
- Response: act_ok=0 for cycles 21-24 and 1 at cycle 25.
- ACT presented at cycle 22: ignored, cmd_err=1 at cycle 23.
REQ-038 Scenario 4: t_rfc=0 and t_rcd=0; REF then ACT.
- Response: each next command is legal exactly one cycle after the previous one is accepted.
REQ-039 Scenario 5: t_rfc=200; REF accepted, t_rfc changed to 5 on the next cycle.
- Response: act_ok stays 0 for 199 cycles.
REQ-040 Scenario 6: rst_n=0 for one cycle during ACTIVATING.
- Response: IDLE and bank_open=0 the next cycle; cmd_type=5 afterwards gives cmd_err=1 with no state change.
